// File: rtl/npu_pkg.sv
// -----------------------------------------------------------------------------
// npu_pkg
// Shared types and defaults for the activation output path.
//   pack_state_e : packer job state (IDLE, PACK, DRAIN)
//   act_word_t   : output word record {data, strb, addr, last} at default widths
//   DEFAULT_*    : default element width, lanes per word, word-address width
// -----------------------------------------------------------------------------
package npu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_PACK       = 4;
  localparam int DEFAULT_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_DRAIN = 2'd2
  } pack_state_e;

  typedef struct packed {
    logic [DEFAULT_PACK*DEFAULT_DATA_WIDTH-1:0] data;
    logic [DEFAULT_PACK-1:0]                    strb;
    logic [DEFAULT_ADDR_WIDTH-1:0]              addr;
    logic                                       last;
  } act_word_t;

endpackage

// File: rtl/act_pack_fifo2.sv
// -----------------------------------------------------------------------------
// act_pack_fifo2
// Two-entry valid/ready FIFO with a registered head. A push into a full FIFO
// is accepted when the head is popped in the same cycle.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   push_valid/push_data   : write side; push_ready = not full or popping
//   pop_valid/pop_data     : head of queue (registered)
//   pop_ready              : consumer takes the head
// -----------------------------------------------------------------------------
module act_pack_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  input  logic             pop_ready
);

  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic [1:0]       cnt_r;
  logic             push_s;
  logic             pop_s;

  assign pop_valid  = (cnt_r != 2'd0);
  assign push_ready = (cnt_r != 2'd2) || pop_ready;
  assign pop_data   = head_r;
  assign push_s     = push_valid && push_ready;
  assign pop_s      = pop_valid && pop_ready;

  // Storage and occupancy; the head is zeroed when the FIFO empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r <= {WIDTH{1'b0}};
      tail_r <= {WIDTH{1'b0}};
      cnt_r  <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (cnt_r == 2'd0) begin
            head_r <= push_data;
          end else begin
            tail_r <= push_data;
          end
          cnt_r <= cnt_r + 2'd1;
        end
        2'b01: begin
          head_r <= (cnt_r == 2'd2) ? tail_r : {WIDTH{1'b0}};
          tail_r <= {WIDTH{1'b0}};
          cnt_r  <= cnt_r - 2'd1;
        end
        2'b11: begin
          if (cnt_r == 2'd1) begin
            head_r <= push_data;
          end else begin
            head_r <= tail_r;
            tail_r <= push_data;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/act_output_packer.sv
// -----------------------------------------------------------------------------
// act_output_packer
// Packs PACK signed elements from the activation unit into one little-endian
// word (lane 0 in the LSBs) and writes words with lane strobes and an
// incrementing word address to the output buffer through a 2-entry FIFO.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   start, base_addr       : begin a job at word address base_addr
//   valid_in/data_in/last_in : element stream, no backpressure
//   in_ready               : advisory, element can be taken this cycle
//   out_valid/out_ready    : write port handshake
//   out_data/out_strb/out_addr/out_last : FIFO head word
//   busy, done             : job in progress, one-cycle drain-complete pulse
//   overflow_err           : sticky, an element was dropped
//   word_cnt               : words transferred this job (ACT_PACK_WORD_CNT_EN)
// Optional macro: ACT_PACK_WORD_CNT_EN
// -----------------------------------------------------------------------------
module act_output_packer
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PACK       = DEFAULT_PACK,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         last_in,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PACK*DATA_WIDTH-1:0]   out_data,
  output logic [PACK-1:0]              out_strb,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow_err
`ifdef ACT_PACK_WORD_CNT_EN
  ,
  output logic [ADDR_WIDTH-1:0]        word_cnt
`endif
);

  localparam int LANE_W = $clog2(PACK);
  localparam int WORD_W = PACK * DATA_WIDTH;
  localparam int PAY_W  = WORD_W + PACK + ADDR_WIDTH + 1;

  pack_state_e         state_r;
  logic [LANE_W-1:0]   lane_cnt_r;
  logic [WORD_W-1:0]   asm_data_r;
  logic [PACK-1:0]     asm_strb_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                overflow_r;

  logic [WORD_W-1:0]   word_data_s;
  logic [PACK-1:0]     word_strb_s;
  logic                push_ready_s;
  logic                accept_s;
  logic                complete_s;
  logic                start_take_s;
  logic                done_s;
  logic [PAY_W-1:0]    push_data_s;
  logic [PAY_W-1:0]    head_s;

  // The FIFO's push_ready already folds in "full but popping this cycle".
  assign in_ready     = (state_r == ST_PACK) && push_ready_s;
  assign accept_s     = in_ready && valid_in;
  assign complete_s   = accept_s && ((lane_cnt_r == LANE_W'(PACK - 1)) || last_in);
  assign done_s       = (state_r == ST_DRAIN) && !out_valid;
  assign start_take_s = start && ((state_r == ST_IDLE) || done_s);
  assign busy         = (state_r != ST_IDLE);
  assign done         = done_s;
  assign overflow_err = overflow_r;

  // Current assembly register with the incoming element merged into its lane.
  always_comb begin
    word_data_s = asm_data_r;
    word_strb_s = asm_strb_r;
    word_data_s[lane_cnt_r*DATA_WIDTH +: DATA_WIDTH] = data_in;
    word_strb_s[lane_cnt_r] = 1'b1;
  end

  assign push_data_s = {word_data_s, word_strb_s, addr_r, last_in};

  act_pack_fifo2 #(.WIDTH(PAY_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (complete_s),
    .push_data  (push_data_s),
    .push_ready (push_ready_s),
    .pop_valid  (out_valid),
    .pop_data   (head_s),
    .pop_ready  (out_ready)
  );

  assign out_data = head_s[PAY_W-1 -: WORD_W];
  assign out_strb = head_s[ADDR_WIDTH+PACK : ADDR_WIDTH+1];
  assign out_addr = head_s[ADDR_WIDTH:1];
  assign out_last = head_s[0];

  // Job state machine, lane assembly, word address and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      lane_cnt_r <= {LANE_W{1'b0}};
      asm_data_r <= {WORD_W{1'b0}};
      asm_strb_r <= {PACK{1'b0}};
      addr_r     <= {ADDR_WIDTH{1'b0}};
      overflow_r <= 1'b0;
    end else if (start_take_s) begin
      // A start coinciding with done chains straight into the next job.
      state_r    <= ST_PACK;
      lane_cnt_r <= {LANE_W{1'b0}};
      asm_data_r <= {WORD_W{1'b0}};
      asm_strb_r <= {PACK{1'b0}};
      addr_r     <= base_addr;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        ST_PACK: begin
          if (accept_s) begin
            if (complete_s) begin
              // Cleared so a later partial word has zero unfilled lanes.
              lane_cnt_r <= {LANE_W{1'b0}};
              asm_data_r <= {WORD_W{1'b0}};
              asm_strb_r <= {PACK{1'b0}};
              addr_r     <= addr_r + ADDR_WIDTH'(1);
            end else begin
              lane_cnt_r <= lane_cnt_r + LANE_W'(1);
              asm_data_r <= word_data_s;
              asm_strb_r <= word_strb_s;
            end
            if (last_in) begin
              state_r <= ST_DRAIN;
            end
          end else if (valid_in) begin
            overflow_r <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (done_s) begin
            state_r <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ACT_PACK_WORD_CNT_EN
  // Words transferred this job; saturates and holds after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= {ADDR_WIDTH{1'b0}};
    end else if (start_take_s) begin
      word_cnt <= {ADDR_WIDTH{1'b0}};
    end else if (out_valid && out_ready && (word_cnt != {ADDR_WIDTH{1'b1}})) begin
      word_cnt <= word_cnt + ADDR_WIDTH'(1);
    end
  end
`else
  // Word counter not built in this configuration.
`endif

endmodule
